// File: rtl/gpi_input_conditioner_if.sv
// Control/status bundle between core GPIO logic and the pad input conditioner.
// Inputs to the conditioner flow master -> slave; conditioned results flow back.
interface gpi_input_conditioner_if #(
    parameter int CNT_W = 8
);
    logic             DI_I;
    logic             IE_I;
    logic             POL_I;
    logic             FILT_EN_I;
    logic [CNT_W-1:0] FILT_LEN_I;
    logic [1:0]       EDGE_SEL_I;
    logic             CLR_I;
    logic             DI_SYNC_O;
    logic             EDGE_O;
    logic             EVT_PEND_O;

    modport master (
        output DI_I, IE_I, POL_I, FILT_EN_I, FILT_LEN_I, EDGE_SEL_I, CLR_I,
        input  DI_SYNC_O, EDGE_O, EVT_PEND_O
    );

    modport slave (
        input  DI_I, IE_I, POL_I, FILT_EN_I, FILT_LEN_I, EDGE_SEL_I, CLR_I,
        output DI_SYNC_O, EDGE_O, EVT_PEND_O
    );
endinterface

// File: rtl/gpi_input_conditioner.sv
// Pad input conditioner: synchronizer, programmable glitch filter, edge detect
// and sticky event flag, all registered on CLK_I.
module gpi_input_conditioner #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic                   CLK_I,
    input  logic                   RST_I,
    gpi_input_conditioner_if.slave bus
);
    typedef enum logic {STABLE, QUALIFY} state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_lvl;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_edge;
    logic                   r_evt;

    state_t                 w_state;
    logic                   w_s;
    logic                   w_commit;
    logic                   w_lvl_nxt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic                   w_edge_nxt;

    // IE_I masks before the first flop so a disable propagates like a real input change.
    always_ff @(posedge CLK_I) begin
        if (RST_I) r_sync <= '0;
        else       r_sync <= {r_sync[SYNC_STAGES-2:0], bus.DI_I & bus.IE_I};
    end

    assign w_s     = r_sync[SYNC_STAGES-1] ^ bus.POL_I;
    assign w_state = (w_s == r_lvl) ? STABLE : QUALIFY;

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            r_lvl <= 1'b0;
            r_cnt <= '0;
        end else begin
            r_lvl <= w_lvl_nxt;
            r_cnt <= w_cnt_nxt;
        end
    end

    // >= lets a lowered FILT_LEN_I commit immediately and keeps r_cnt from wrapping.
    always_comb begin
        w_commit  = 1'b0;
        w_lvl_nxt = r_lvl;
        w_cnt_nxt = '0;
        if (w_state == QUALIFY) begin
            if (!bus.FILT_EN_I || (r_cnt >= bus.FILT_LEN_I)) begin
                w_commit  = 1'b1;
                w_lvl_nxt = w_s;
            end else begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_edge_nxt = 1'b0;
        if (w_commit)
            w_edge_nxt = (w_s & bus.EDGE_SEL_I[0]) | (~w_s & bus.EDGE_SEL_I[1]);
    end

    // Set beats clear when an edge and CLR_I coincide.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            r_edge <= 1'b0;
            r_evt  <= 1'b0;
        end else begin
            r_edge <= w_edge_nxt;
            r_evt  <= r_edge | (r_evt & ~bus.CLR_I);
        end
    end

    assign bus.DI_SYNC_O  = r_lvl;
    assign bus.EDGE_O     = r_edge;
    assign bus.EVT_PEND_O = r_evt;
endmodule

// File: tb/tb_gpi_input_conditioner.sv
// Directed bench for gpi_input_conditioner; expected values are hand-derived
// cycle counts relative to the first edge sampling a new DI_I value.
module tb_gpi_input_conditioner;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    gpi_input_conditioner_if #(.CNT_W(8)) bus ();

    gpi_input_conditioner #(.SYNC_STAGES(2), .CNT_W(8)) dut (
        .CLK_I (clk),
        .RST_I (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic defaults();
        bus.DI_I       = 1'b0;
        bus.IE_I       = 1'b1;
        bus.POL_I      = 1'b0;
        bus.FILT_EN_I  = 1'b0;
        bus.FILT_LEN_I = 8'd0;
        bus.EDGE_SEL_I = 2'b11;
        bus.CLR_I      = 1'b0;
    endtask

    task automatic test_reset();
        defaults();
        bus.DI_I = 1'b1;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if ({bus.DI_SYNC_O, bus.EDGE_O, bus.EVT_PEND_O} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_outputs: got %b expected 000", {bus.DI_SYNC_O, bus.EDGE_O, bus.EVT_PEND_O});
        end
        n_cmp++;
        if (dut.r_sync !== 2'b00) begin
            n_err++;
            $display("FAIL reset_sync: got %b expected 00", dut.r_sync);
        end
    endtask

    task automatic test_bypass();
        defaults();
        do_reset();
        bus.DI_I = 1'b1;
        tick(); tick();
        n_cmp++;
        if (bus.DI_SYNC_O !== 1'b0) begin
            n_err++;
            $display("FAIL bypass_early: DI_SYNC_O got %b expected 0", bus.DI_SYNC_O);
        end
        tick();
        n_cmp++;
        if ({bus.DI_SYNC_O, bus.EDGE_O, bus.EVT_PEND_O} !== 3'b110) begin
            n_err++;
            $display("FAIL bypass_rise: got %b expected 110", {bus.DI_SYNC_O, bus.EDGE_O, bus.EVT_PEND_O});
        end
        tick();
        n_cmp++;
        if ({bus.DI_SYNC_O, bus.EDGE_O, bus.EVT_PEND_O} !== 3'b101) begin
            n_err++;
            $display("FAIL bypass_after: got %b expected 101", {bus.DI_SYNC_O, bus.EDGE_O, bus.EVT_PEND_O});
        end
    endtask

    task automatic test_pol_after_reset();
        defaults();
        bus.POL_I = 1'b1;
        do_reset();
        n_cmp++;
        if (bus.DI_SYNC_O !== 1'b0) begin
            n_err++;
            $display("FAIL pol_reset: DI_SYNC_O got %b expected 0", bus.DI_SYNC_O);
        end
        tick();
        n_cmp++;
        if ({bus.DI_SYNC_O, bus.EDGE_O} !== 2'b11) begin
            n_err++;
            $display("FAIL pol_qualify: got %b expected 11", {bus.DI_SYNC_O, bus.EDGE_O});
        end
    endtask

    task automatic test_filter();
        logic seen;
        defaults();
        bus.FILT_EN_I  = 1'b1;
        bus.FILT_LEN_I = 8'd4;
        do_reset();
        bus.DI_I = 1'b1;
        repeat (4) tick();
        bus.DI_I = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            seen = seen | bus.DI_SYNC_O | bus.EDGE_O;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_err++;
            $display("FAIL filter_glitch: activity got %b expected 0", seen);
        end
        bus.DI_I = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (k == 4) bus.DI_I = 1'b0;
            n_cmp++;
            if ({bus.DI_SYNC_O, bus.EDGE_O} !== {k >= 6, k == 6}) begin
                n_err++;
                $display("FAIL filter_pass edge %0d: got %b expected %b", k,
                         {bus.DI_SYNC_O, bus.EDGE_O}, {k >= 6, k == 6});
            end
        end
    endtask

    task automatic test_len_change();
        defaults();
        bus.FILT_EN_I  = 1'b1;
        bus.FILT_LEN_I = 8'd10;
        do_reset();
        bus.DI_I = 1'b1;
        repeat (8) tick();
        n_cmp++;
        if ({bus.DI_SYNC_O, dut.r_cnt} !== {1'b0, 8'd6}) begin
            n_err++;
            $display("FAIL len_mid: lvl/cnt got %b/%0d expected 0/6", bus.DI_SYNC_O, dut.r_cnt);
        end
        bus.FILT_LEN_I = 8'd3;
        tick();
        n_cmp++;
        if ({bus.DI_SYNC_O, bus.EDGE_O, dut.r_cnt} !== {2'b11, 8'd0}) begin
            n_err++;
            $display("FAIL len_lowered: lvl/edge/cnt got %b/%b/%0d expected 1/1/0",
                     bus.DI_SYNC_O, bus.EDGE_O, dut.r_cnt);
        end
    endtask

    task automatic test_edge_sel();
        int pulses;
        defaults();
        bus.EDGE_SEL_I = 2'b01;
        do_reset();
        pulses = 0;
        bus.DI_I = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (k == 3) bus.DI_I = 1'b0;
            if (bus.EDGE_O) pulses++;
        end
        n_cmp++;
        if (pulses !== 1) begin
            n_err++;
            $display("FAIL edge_sel_rise_only: pulses got %0d expected 1", pulses);
        end
        bus.CLR_I = 1'b1;
        tick();
        bus.CLR_I = 1'b0;
        n_cmp++;
        if (bus.EVT_PEND_O !== 1'b0) begin
            n_err++;
            $display("FAIL evt_clear: EVT_PEND_O got %b expected 0", bus.EVT_PEND_O);
        end
        bus.DI_I = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if ({bus.EDGE_O, bus.EVT_PEND_O} !== 2'b10) begin
            n_err++;
            $display("FAIL edge_before_clr: got %b expected 10", {bus.EDGE_O, bus.EVT_PEND_O});
        end
        bus.CLR_I = 1'b1;
        tick();
        bus.CLR_I = 1'b0;
        n_cmp++;
        if (bus.EVT_PEND_O !== 1'b1) begin
            n_err++;
            $display("FAIL set_wins: EVT_PEND_O got %b expected 1", bus.EVT_PEND_O);
        end
    endtask

    task automatic test_ie();
        defaults();
        do_reset();
        bus.DI_I = 1'b1;
        repeat (4) tick();
        bus.IE_I = 1'b0;
        tick(); tick();
        n_cmp++;
        if (bus.DI_SYNC_O !== 1'b1) begin
            n_err++;
            $display("FAIL ie_hold: DI_SYNC_O got %b expected 1", bus.DI_SYNC_O);
        end
        tick();
        n_cmp++;
        if ({bus.DI_SYNC_O, bus.EDGE_O} !== 2'b01) begin
            n_err++;
            $display("FAIL ie_fall: got %b expected 01", {bus.DI_SYNC_O, bus.EDGE_O});
        end
    endtask

    task automatic test_reset_mid();
        defaults();
        bus.FILT_EN_I  = 1'b1;
        bus.FILT_LEN_I = 8'd8;
        do_reset();
        bus.DI_I = 1'b1;
        repeat (7) tick();
        n_cmp++;
        if (dut.r_cnt !== 8'd5) begin
            n_err++;
            $display("FAIL mid_cnt: cnt got %0d expected 5", dut.r_cnt);
        end
        do_reset();
        n_cmp++;
        if ({bus.DI_SYNC_O, bus.EDGE_O, bus.EVT_PEND_O, dut.r_cnt} !== 11'd0) begin
            n_err++;
            $display("FAIL mid_reset: lvl/edge/evt/cnt got %b/%b/%b/%0d expected 0/0/0/0",
                     bus.DI_SYNC_O, bus.EDGE_O, bus.EVT_PEND_O, dut.r_cnt);
        end
        repeat (3) tick();
        n_cmp++;
        if (dut.r_cnt !== 8'd1) begin
            n_err++;
            $display("FAIL restart_cnt: cnt got %0d expected 1", dut.r_cnt);
        end
        repeat (7) tick();
        n_cmp++;
        if (bus.DI_SYNC_O !== 1'b0) begin
            n_err++;
            $display("FAIL restart_early: DI_SYNC_O got %b expected 0", bus.DI_SYNC_O);
        end
        tick();
        n_cmp++;
        if (bus.DI_SYNC_O !== 1'b1) begin
            n_err++;
            $display("FAIL restart_commit: DI_SYNC_O got %b expected 1", bus.DI_SYNC_O);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        defaults();
        test_reset();
        test_bypass();
        test_pol_after_reset();
        test_filter();
        test_len_change();
        test_edge_sel();
        test_ie();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/gpi_input_conditioner.md
# gpi_input_conditioner

Receive-side conditioner for a general-purpose I/O pad: takes the raw, asynchronous data bit delivered by the pad input cell and produces a clean, synchronous level for core logic. It provides:
- synchronization into the core clock domain, with input-enable masking and optional inversion;
- a programmable glitch filter;
- edge detection with a sticky event flag.

It sits in the core power domain between the pad ring and the GPIO/interrupt logic. It is the input-path counterpart of the output pad drivers.

## Interface

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops on DI_I; legal range 2..4.
- CNT_W, 8, width of the filter length and qualification counter.

Ports:
- CLK_I  input  1  core clock.
- RST_I  input  1  reset; synchronous, active-high.
- DI_I  input  1  raw pad input data from the pad input cell; asynchronous to CLK_I.
- IE_I  input  1  input enable; 0 forces the synchronizer input to 0.
- POL_I  input  1  1 inverts the synchronized sample.
- FILT_EN_I  input  1  1 enables the glitch filter.
- FILT_LEN_I  input  CNT_W  filter length N; a change is accepted after N+1 consecutive differing samples.
- EDGE_SEL_I  input  2  edge select: 00 none, 01 rising, 10 falling, 11 both.
- CLR_I  input  1  clears EVT_PEND_O.
- DI_SYNC_O  output  1  filtered, synchronous level.
- EDGE_O  output  1  one-cycle pulse on a selected edge of DI_SYNC_O.
- EVT_PEND_O  output  1  sticky event flag.

## Operation

**Sync chain**
- The chain is SYNC_STAGES flops. The first flop's input is DI_I & IE_I.
- The sample is s = last flop XOR POL_I.

**Filter FSM**
- State is held in lvl_q (drives DI_SYNC_O) and cnt_q (CNT_W bits).
- STABLE (s == lvl_q): cnt_q <= 0.
- QUALIFY (s != lvl_q):
  - if FILT_EN_I == 0 or cnt_q >= FILT_LEN_I: lvl_q <= s, cnt_q <= 0;
  - else cnt_q <= cnt_q + 1.
- Any single cycle with s == lvl_q during QUALIFY discards the count (glitch rejected).
- The comparison is >=. If FILT_LEN_I is lowered mid-qualify below cnt_q, the change commits on the next edge. cnt_q never wraps.
- FILT_LEN_I = 0 with the filter enabled behaves identically to bypass.

**Edge detect**
- On a lvl_q update, EDGE_O is asserted in the same cycle the new lvl_q value appears when:
  - the update is 0->1 and EDGE_SEL_I[0] = 1, or
  - the update is 1->0 and EDGE_SEL_I[1] = 1.
- EDGE_O is registered and lasts exactly one cycle.
- Back-to-back updates, only possible in bypass, give one pulse per update.

**Event flag**
- EVT_PEND_O is set by EDGE_O and cleared by CLR_I.
- If an edge and CLR_I occur in the same cycle, set wins and EVT_PEND_O stays 1.

**Mode changes**
- IE_I falling drives the sync chain to 0. This propagates like a normal input change and can raise a falling edge.
- POL_I toggling is treated as an input change and passes through the filter.

**Reset**
- RST_I = 1 on a rising CLK_I edge clears the sync flops, lvl_q, cnt_q, EDGE_O and EVT_PEND_O to 0.
- This applies even mid-qualify. After reset, DI_SYNC_O = 0, EDGE_O = 0, EVT_PEND_O = 0.
- With POL_I = 1 and a quiet input after reset, s = 1. The level then qualifies to 1 and may raise a rising edge. This is intended.

## Timing

- Everything is on the CLK_I rising edge. There are no combinational paths from inputs to outputs.
- Let edge 0 be the first edge that samples a new DI_I value.
- DI_SYNC_O changes after edge SYNC_STAGES + N, i.e. SYNC_STAGES + N + 1 edges inclusive. N = 0 when bypassed.
- With SYNC_STAGES = 2 and bypass, the latency is 3 cycles.
- EDGE_O is high in the same cycle as the new DI_SYNC_O value.
- EVT_PEND_O rises one cycle after EDGE_O.
- A glitch narrower than N+1 cycles at the sync output never reaches DI_SYNC_O.
- DI_I metastability is absorbed by the sync chain. Downstream logic relies only on DI_SYNC_O.

## Test plan

Defaults below: SYNC_STAGES = 2, CNT_W = 8, IE_I = 1, POL_I = 0, EDGE_SEL_I = 11.

1. Bypass, DI_I 0->1, held:
   - DI_SYNC_O = 1 in cycle 3 after the sampling edge;
   - EDGE_O pulses in that cycle for 1 cycle;
   - EVT_PEND_O = 1 from the next cycle.
2. FILT_EN_I = 1, FILT_LEN_I = 4:
   - a 4-cycle high pulse on DI_I -> DI_SYNC_O stays 0 and there is no EDGE_O;
   - a 5-cycle pulse -> DI_SYNC_O rises 7 edges after the first sample.
3. FILT_LEN_I = 10, DI_I held high; at cnt_q = 6, FILT_LEN_I is changed to 3 -> DI_SYNC_O updates on the next edge and cnt_q returns to 0.
4. EDGE_SEL_I = 01, DI_I toggles 0->1->0 (bypass) -> exactly one EDGE_O pulse (the rising edge). Then CLR_I is asserted in the same cycle as a new rising EDGE_O -> EVT_PEND_O remains 1.
5. DI_SYNC_O = 1, then IE_I = 0 -> DI_SYNC_O goes to 0 after 3 cycles with a falling EDGE_O.
6. RST_I asserted mid-qualify (FILT_LEN_I = 8, cnt_q = 5) -> the next cycle shows all outputs 0 and cnt_q = 0. Qualification then restarts from 0 after RST_I is released.
